hoplite_switch_buffered: RTL and testbench
==========================================

// Module: hoplite_switch_buffered
// PURPOSE
// - Next-gen Hoplite unidirectional-torus deflection switch: W/N network inputs, E/S outputs, PE exit on S.
// - Adds a parametrised PE injection FIFO with valid/ready (PE never holds a packet on the wire) and
//   saturating deflection/injection counters. One instance per torus node, between neighbour switches and PE.
// PARAMETERS
// - P_W        32  packet width; addrx = pkt[X_AW-1:0], addry = pkt[X_AW+Y_AW-1:X_AW]
// - X_AW        2  X address width
// - Y_AW        2  Y address width
// - X_POS       0  this switch's X coordinate
// - Y_POS       0  this switch's Y coordinate
// - INJ_DEPTH   4  injection FIFO depth, power of 2, >=2
// - CNT_W      16  statistics counter width
// PORTS
// - clk        in   1     clock
// - rst        in   1     synchronous, active-high reset
// - xin_pkt    in   P_W   West input packet
// - xin_vld    in   1     West valid
// - yin_pkt    in   P_W   North input packet
// - yin_vld    in   1     North valid
// - pein_pkt   in   P_W   PE injection packet
// - pein_vld   in   1     PE injection valid
// - pein_rdy   out  1     FIFO accepts (pein_vld & pein_rdy = push)
// - xout_pkt   out  P_W   East output (registered)
// - xout_vld   out  1     East valid
// - yout_pkt   out  P_W   South output; also PE exit data
// - yout_vld   out  1     South valid for next switch
// - peout_vld  out  1     yout_pkt is delivered to this PE
// - inj_level  out  log2(INJ_DEPTH)+1  FIFO occupancy
// - defl_cnt   out  CNT_W N packets deflected to E, saturating
// - inj_cnt    out  CNT_W packets injected into network, saturating
// BEHAVIOUR
// - Reset: all *_vld=0, pkts=0, FIFO empty, inj_level=0, counters=0, pein_rdy=0 during rst, 1 after.
// - Routing (comb, registered to outputs, latency 1 cycle in->out, no backpressure on network):
//   W: addrx!=X_POS -> E; else -> S. W always wins.
//   N: -> S unless S taken by W, then deflect to E (defl_cnt++).
//   PE head (FIFO not empty): addrx!=X_POS -> E iff E free; else -> S iff S free; else wait in FIFO.
// - S output: addry==Y_POS -> peout_vld=1, yout_vld=0; else yout_vld=1, peout_vld=0. PE pkt at S
//   always has yout_vld (PE never routes to itself through S; self-addressed PE pkt goes E around ring).
// - Pop when head granted; inj_cnt++ on pop. Counters stick at all-ones.
// - pein_rdy = !full (from registered count). Push+pop same cycle: level unchanged; push ignored when full.
// - FIFO empty: no injection, head data ignored. Pointers wrap modulo INJ_DEPTH.
// - Reset mid-operation: FIFO contents and in-flight output regs discarded, next cycle idle.
// - Invalid input pkts (vld=0) never grant or count regardless of data.
// STRUCTURE
// - Packet field extraction macros/constants (addrx, addry slices) in shared include.h.
// - Sub-module: sync_fifo (P_W wide, INJ_DEPTH deep, push/pop/full/empty/level), first-word-fall-through.
// - Top: routing/arbitration comb logic, output regs, two saturating counters.
// TESTING
// - Reset then idle -> all vld=0, pein_rdy=1, inj_level=0, counters 0.
// - X_POS=0,Y_POS=0: xin pkt addr(x1,y0) -> next cycle xout_vld=1, same pkt; addr(x0,y0) -> peout_vld=1, yout_vld=0.
// - xin addr(x0,y2) + yin addr(x0,y3) same cycle -> W on S yout_vld=1, N on E xout_vld=1, defl_cnt=1.
// - PE pushes 4 pkts (x1) while xin_vld=1 every cycle -> pein_rdy=0 after 4th, inj_level=4, none injected;
//   xin drops -> one pop/cycle, inj_cnt=4 after 4 cycles, xout order preserved.
// - Full FIFO, push with simultaneous pop -> accepted only if pein_rdy was 1; level stays INJ_DEPTH-consistent.
// - CNT_W=2, 5 deflections -> defl_cnt=3 (saturated); assert rst mid-burst -> FIFO empty, outputs 0 next cycle.

Source files
------------

// File: rtl/hoplite_switch_buffered_pkg.sv
// ============================================================================
// hoplite_switch_buffered_pkg : shared types for the buffered Hoplite switch
// Rev 1.0
// ============================================================================
`default_nettype none

package hoplite_switch_buffered_pkg;

   // Which input currently drives an output port in a given cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_W    = 2'd1,
      SRC_N    = 2'd2,
      SRC_PE   = 2'd3
   } src_e;

endpackage

`default_nettype wire

// File: rtl/hoplite_switch_buffered_fifo.sv
// ============================================================================
// hoplite_switch_buffered_fifo : first-word-fall-through PE injection FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module hoplite_switch_buffered_fifo
   import hoplite_switch_buffered_pkg::*;
#(
   parameter int P_W   = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [P_W-1:0]             push_data_i,
   input  logic                       pop_i,
   output logic [P_W-1:0]             head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [P_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] count_q;
   logic             w_push, w_pop;

   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (w_push && !w_pop)      count_q <= count_q + 1'b1;
         else if (w_pop && !w_push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/hoplite_switch_buffered.sv
// ============================================================================
// hoplite_switch_buffered : Hoplite torus deflection switch with PE injection
// FIFO and saturating deflection/injection counters.  Rev 1.0
// ============================================================================
`default_nettype none

module hoplite_switch_buffered
   import hoplite_switch_buffered_pkg::*;
#(
   parameter int P_W       = 32,
   parameter int X_AW      = 2,
   parameter int Y_AW      = 2,
   parameter int X_POS     = 0,
   parameter int Y_POS     = 0,
   parameter int INJ_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [P_W-1:0]               xin_pkt,
   input  logic                         xin_vld,
   input  logic [P_W-1:0]               yin_pkt,
   input  logic                         yin_vld,
   input  logic [P_W-1:0]               pein_pkt,
   input  logic                         pein_vld,
   output logic                         pein_rdy,
   output logic [P_W-1:0]               xout_pkt,
   output logic                         xout_vld,
   output logic [P_W-1:0]               yout_pkt,
   output logic                         yout_vld,
   output logic                         peout_vld,
   output logic [$clog2(INJ_DEPTH):0]   inj_level,
   output logic [CNT_W-1:0]             defl_cnt,
   output logic [CNT_W-1:0]             inj_cnt
);

   localparam logic [X_AW-1:0] C_XP = X_AW'(X_POS);
   localparam logic [Y_AW-1:0] C_YP = Y_AW'(Y_POS);

   logic [P_W-1:0]   head;
   logic             fifo_full, fifo_empty;
   logic             w_pop, w_defl;
   src_e             w_e_src, w_s_src;
   logic [P_W-1:0]   xout_pkt_d, yout_pkt_d;
   logic             yout_vld_d, peout_vld_d;

   logic [P_W-1:0]   xout_pkt_q, yout_pkt_q;
   logic             xout_vld_q, yout_vld_q, peout_vld_q;
   logic [CNT_W-1:0] defl_cnt_q, inj_cnt_q;

   assign pein_rdy = !rst && !fifo_full;

   hoplite_switch_buffered_fifo #(
      .P_W   (P_W),
      .DEPTH (INJ_DEPTH)
   ) u_inj_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (pein_vld && pein_rdy),
      .push_data_i (pein_pkt),
      .pop_i       (w_pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (inj_level)
   );

   // Priority W > N > PE; a self-addressed PE packet takes E around the ring.
   always_comb begin
      w_e_src = SRC_NONE;
      w_s_src = SRC_NONE;
      w_defl  = 1'b0;
      w_pop   = 1'b0;
      if (xin_vld) begin
         if (xin_pkt[X_AW-1:0] != C_XP) w_e_src = SRC_W;
         else                           w_s_src = SRC_W;
      end
      if (yin_vld) begin
         if (w_s_src == SRC_NONE) begin
            w_s_src = SRC_N;
         end else begin
            w_e_src = SRC_N;
            w_defl  = 1'b1;
         end
      end
      if (!fifo_empty) begin
         if (head[X_AW-1:0] != C_XP || head[X_AW+Y_AW-1:X_AW] == C_YP) begin
            if (w_e_src == SRC_NONE) begin
               w_e_src = SRC_PE;
               w_pop   = 1'b1;
            end
         end else if (w_s_src == SRC_NONE) begin
            w_s_src = SRC_PE;
            w_pop   = 1'b1;
         end
      end
   end

   always_comb begin
      case (w_e_src)
         SRC_W:   xout_pkt_d = xin_pkt;
         SRC_N:   xout_pkt_d = yin_pkt;
         SRC_PE:  xout_pkt_d = head;
         default: xout_pkt_d = '0;
      endcase
      case (w_s_src)
         SRC_W:   yout_pkt_d = xin_pkt;
         SRC_N:   yout_pkt_d = yin_pkt;
         SRC_PE:  yout_pkt_d = head;
         default: yout_pkt_d = '0;
      endcase
      yout_vld_d  = 1'b0;
      peout_vld_d = 1'b0;
      if (w_s_src == SRC_PE) begin
         yout_vld_d = 1'b1;
      end else if (w_s_src != SRC_NONE) begin
         if (yout_pkt_d[X_AW+Y_AW-1:X_AW] == C_YP) peout_vld_d = 1'b1;
         else                                      yout_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xout_pkt_q  <= '0;
         xout_vld_q  <= 1'b0;
         yout_pkt_q  <= '0;
         yout_vld_q  <= 1'b0;
         peout_vld_q <= 1'b0;
         defl_cnt_q  <= '0;
         inj_cnt_q   <= '0;
      end else begin
         xout_pkt_q  <= xout_pkt_d;
         xout_vld_q  <= (w_e_src != SRC_NONE);
         yout_pkt_q  <= yout_pkt_d;
         yout_vld_q  <= yout_vld_d;
         peout_vld_q <= peout_vld_d;
         if (w_defl && defl_cnt_q != '1) defl_cnt_q <= defl_cnt_q + 1'b1;
         if (w_pop && inj_cnt_q != '1)   inj_cnt_q  <= inj_cnt_q + 1'b1;
      end
   end

   assign xout_pkt  = xout_pkt_q;
   assign xout_vld  = xout_vld_q;
   assign yout_pkt  = yout_pkt_q;
   assign yout_vld  = yout_vld_q;
   assign peout_vld = peout_vld_q;
   assign defl_cnt  = defl_cnt_q;
   assign inj_cnt   = inj_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hoplite_switch_buffered.sv
// ============================================================================
// tb_hoplite_switch_buffered : scenario tasks plus randomized traffic against
// a queue-based reference model of switch node (0,0).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_hoplite_switch_buffered;

   localparam int P_W   = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [P_W-1:0] xin_pkt, yin_pkt, pein_pkt;
   logic          xin_vld, yin_vld, pein_vld;
   logic          pein_rdy, xout_vld, yout_vld, peout_vld;
   logic [P_W-1:0] xout_pkt, yout_pkt;
   logic [2:0]    inj_level;
   logic [15:0]   defl_cnt, inj_cnt;

   logic          s_pein_rdy, s_xout_vld, s_yout_vld, s_peout_vld;
   logic [P_W-1:0] s_xout_pkt, s_yout_pkt;
   logic [2:0]    s_inj_level;
   logic [1:0]    s_defl_cnt, s_inj_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hoplite_switch_buffered u_dut (
      .clk(clk), .rst(rst),
      .xin_pkt(xin_pkt), .xin_vld(xin_vld), .yin_pkt(yin_pkt), .yin_vld(yin_vld),
      .pein_pkt(pein_pkt), .pein_vld(pein_vld), .pein_rdy(pein_rdy),
      .xout_pkt(xout_pkt), .xout_vld(xout_vld), .yout_pkt(yout_pkt), .yout_vld(yout_vld),
      .peout_vld(peout_vld), .inj_level(inj_level), .defl_cnt(defl_cnt), .inj_cnt(inj_cnt)
   );

   hoplite_switch_buffered #(.CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst),
      .xin_pkt(xin_pkt), .xin_vld(xin_vld), .yin_pkt(yin_pkt), .yin_vld(yin_vld),
      .pein_pkt(pein_pkt), .pein_vld(pein_vld), .pein_rdy(s_pein_rdy),
      .xout_pkt(s_xout_pkt), .xout_vld(s_xout_vld), .yout_pkt(s_yout_pkt), .yout_vld(s_yout_vld),
      .peout_vld(s_peout_vld), .inj_level(s_inj_level), .defl_cnt(s_defl_cnt), .inj_cnt(s_inj_cnt)
   );

   // ---------------- reference model ----------------
   logic [P_W-1:0] mq[$];
   logic [P_W-1:0] exp_xpkt, exp_ypkt;
   logic           exp_xvld, exp_yvld, exp_pevld;
   int             exp_defl, exp_inj;

   function automatic logic [P_W-1:0] mk(input int x, input int y);
      logic [P_W-1:0] r;
      r      = P_W'($urandom);
      r[1:0] = x[1:0];
      r[3:2] = y[1:0];
      return r;
   endfunction

   function automatic int ax(input logic [P_W-1:0] p);
      return int'(p[1:0]);
   endfunction

   function automatic int ay(input logic [P_W-1:0] p);
      return int'(p[3:2]);
   endfunction

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic model_step();
      bit             e_used, s_used, s_pe, pop;
      logic [P_W-1:0] e_p, s_p, hd;
      int             sz;
      e_used = 0; s_used = 0; s_pe = 0; pop = 0;
      e_p = '0; s_p = '0;
      sz = mq.size();
      if (rst) begin
         mq.delete();
         exp_xvld = 0; exp_yvld = 0; exp_pevld = 0;
         exp_xpkt = '0; exp_ypkt = '0;
         exp_defl = 0; exp_inj = 0;
         return;
      end
      if (xin_vld) begin
         if (ax(xin_pkt) != 0) begin e_used = 1; e_p = xin_pkt; end
         else begin s_used = 1; s_p = xin_pkt; end
      end
      if (yin_vld) begin
         if (!s_used) begin s_used = 1; s_p = yin_pkt; end
         else begin e_used = 1; e_p = yin_pkt; exp_defl++; end
      end
      if (sz > 0) begin
         hd = mq[0];
         if (ax(hd) != 0 || ay(hd) == 0) begin
            if (!e_used) begin e_used = 1; e_p = hd; pop = 1; end
         end else if (!s_used) begin
            s_used = 1; s_p = hd; s_pe = 1; pop = 1;
         end
      end
      if (pop) begin
         void'(mq.pop_front());
         exp_inj++;
      end
      if (pein_vld && sz < DEPTH) mq.push_back(pein_pkt);
      exp_xvld  = e_used;
      exp_xpkt  = e_p;
      exp_ypkt  = s_p;
      exp_yvld  = s_used && (s_pe || ay(s_p) != 0);
      exp_pevld = s_used && !s_pe && ay(s_p) == 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      xin_vld = 0; yin_vld = 0; pein_vld = 0;
      xin_pkt = '0; yin_pkt = '0; pein_pkt = '0;
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs();
      tick();
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; idle_inputs();
      #1;
      checks++;
      if (pein_rdy !== 1'b0) begin
         failures++; $display("FAIL reset_rdy_in_rst: got %b exp 0", pein_rdy);
      end
      tick(); tick();
      rst = 0;
      tick();
      checks++;
      if ({xout_vld, yout_vld, peout_vld, pein_rdy, inj_level, defl_cnt, inj_cnt} !==
          {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0}) begin
         failures++;
         $display("FAIL reset_idle: got xv=%b yv=%b pv=%b rdy=%b lvl=%0d defl=%0d inj=%0d exp 0 0 0 1 0 0 0",
                  xout_vld, yout_vld, peout_vld, pein_rdy, inj_level, defl_cnt, inj_cnt);
      end
      checks++;
      if ({xout_pkt, yout_pkt} !== '0) begin
         failures++; $display("FAIL reset_pkts: got %h %h exp 0", xout_pkt, yout_pkt);
      end
   endtask

   task automatic test_route_w();
      logic [P_W-1:0] p;
      p = mk(1, 0);
      xin_vld = 1; xin_pkt = p;
      tick();
      checks++;
      if ({xout_vld, xout_pkt, yout_vld, peout_vld} !== {1'b1, p, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL route_w_east: got xv=%b pkt=%h yv=%b pv=%b exp 1 %h 0 0",
                  xout_vld, xout_pkt, yout_vld, peout_vld, p);
      end
      p = mk(0, 0);
      xin_pkt = p;
      tick();
      checks++;
      if ({peout_vld, yout_vld, yout_pkt, xout_vld} !== {1'b1, 1'b0, p, 1'b0}) begin
         failures++;
         $display("FAIL route_w_exit: got pv=%b yv=%b pkt=%h xv=%b exp 1 0 %h 0",
                  peout_vld, yout_vld, yout_pkt, xout_vld, p);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_deflect();
      logic [P_W-1:0] pw, pn;
      do_reset();
      pw = mk(0, 2); pn = mk(0, 3);
      xin_vld = 1; xin_pkt = pw; yin_vld = 1; yin_pkt = pn;
      tick();
      checks++;
      if ({yout_vld, peout_vld, yout_pkt, xout_vld, xout_pkt} !== {1'b1, 1'b0, pw, 1'b1, pn}) begin
         failures++;
         $display("FAIL deflect_route: got yv=%b pv=%b y=%h xv=%b x=%h exp 1 0 %h 1 %h",
                  yout_vld, peout_vld, yout_pkt, xout_vld, xout_pkt, pw, pn);
      end
      checks++;
      if (defl_cnt !== 16'd1) begin
         failures++; $display("FAIL deflect_cnt: got %0d exp 1", defl_cnt);
      end
      idle_inputs();
      tick();
   endtask

   task automatic fill_blocked(output logic [P_W-1:0] p[4]);
      for (int i = 0; i < 4; i++) begin
         p[i] = mk(1, $urandom_range(0, 3));
         xin_vld = 1; xin_pkt = mk(1, $urandom_range(0, 3));
         pein_vld = 1; pein_pkt = p[i];
         tick();
      end
   endtask

   task automatic test_fifo_fill();
      logic [P_W-1:0] p[4];
      do_reset();
      fill_blocked(p);
      checks++;
      if ({pein_rdy, inj_level, inj_cnt} !== {1'b0, 3'd4, 16'd0}) begin
         failures++;
         $display("FAIL fifo_full: got rdy=%b lvl=%0d inj=%0d exp 0 4 0", pein_rdy, inj_level, inj_cnt);
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({xout_vld, xout_pkt} !== {1'b1, p[i]}) begin
            failures++;
            $display("FAIL fifo_drain_order[%0d]: got %b %h exp 1 %h", i, xout_vld, xout_pkt, p[i]);
         end
      end
      checks++;
      if ({inj_cnt, inj_level, pein_rdy} !== {16'd4, 3'd0, 1'b1}) begin
         failures++;
         $display("FAIL fifo_drained: got inj=%0d lvl=%0d rdy=%b exp 4 0 1", inj_cnt, inj_level, pein_rdy);
      end
   endtask

   task automatic test_full_push_pop();
      logic [P_W-1:0] p[4];
      logic [P_W-1:0] ex1, ex2;
      logic [P_W-1:0] order[5];
      do_reset();
      fill_blocked(p);
      ex1 = mk(1, 1); ex2 = mk(1, 2);
      xin_vld = 0; pein_vld = 1; pein_pkt = ex1;
      tick();
      checks++;
      if ({inj_level, xout_pkt, pein_rdy} !== {3'd3, p[0], 1'b1}) begin
         failures++;
         $display("FAIL full_pop_push_ignored: got lvl=%0d x=%h rdy=%b exp 3 %h 1",
                  inj_level, xout_pkt, pein_rdy, p[0]);
      end
      pein_pkt = ex2;
      tick();
      checks++;
      if ({inj_level, xout_pkt} !== {3'd3, p[1]}) begin
         failures++;
         $display("FAIL push_pop_level: got lvl=%0d x=%h exp 3 %h", inj_level, xout_pkt, p[1]);
      end
      pein_vld = 0;
      order = '{p[2], p[3], ex2, '0, '0};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({xout_vld, xout_pkt} !== {1'b1, order[i]}) begin
            failures++;
            $display("FAIL push_pop_order[%0d]: got %b %h exp 1 %h", i, xout_vld, xout_pkt, order[i]);
         end
      end
      checks++;
      if (inj_level !== 3'(mq.size()) || mq.size() != 0) begin
         failures++; $display("FAIL push_pop_empty: got lvl=%0d exp 0", inj_level);
      end
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         xin_vld = 1; xin_pkt = mk(0, 2); yin_vld = 1; yin_pkt = mk(0, 3);
         tick();
      end
      checks++;
      if ({s_defl_cnt, defl_cnt} !== {2'd3, 16'd5}) begin
         failures++; $display("FAIL defl_saturate: got sat=%0d wide=%0d exp 3 5", s_defl_cnt, defl_cnt);
      end
      yin_vld = 0;
      for (int i = 0; i < 2; i++) begin
         xin_vld = 1; xin_pkt = mk(1, 0);
         pein_vld = 1; pein_pkt = mk(1, 3);
         tick();
      end
      rst = 1;
      tick();
      checks++;
      if ({xout_vld, yout_vld, peout_vld, pein_rdy, inj_level, defl_cnt, inj_cnt, s_defl_cnt} !==
          {1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 2'd0}) begin
         failures++;
         $display("FAIL midrst_clear: got xv=%b yv=%b pv=%b rdy=%b lvl=%0d defl=%0d inj=%0d exp 0 0 0 0 0 0 0",
                  xout_vld, yout_vld, peout_vld, pein_rdy, inj_level, defl_cnt, inj_cnt);
      end
      rst = 0; idle_inputs();
      tick();
      checks++;
      if ({xout_vld, yout_vld, peout_vld, pein_rdy, inj_level, inj_cnt} !==
          {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0}) begin
         failures++;
         $display("FAIL midrst_idle: got xv=%b yv=%b pv=%b rdy=%b lvl=%0d inj=%0d exp 0 0 0 1 0 0",
                  xout_vld, yout_vld, peout_vld, pein_rdy, inj_level, inj_cnt);
      end
   endtask

   task automatic test_random();
      logic exp_rdy;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 149) == 0);
         xin_vld  = ($urandom_range(0, 99) < 45);
         yin_vld  = ($urandom_range(0, 99) < 45);
         pein_vld = ($urandom_range(0, 99) < 60);
         xin_pkt  = P_W'($urandom);
         yin_pkt  = P_W'($urandom);
         pein_pkt = P_W'($urandom);
         tick();
         exp_rdy = !rst && (mq.size() < DEPTH);
         checks++;
         if ({xout_vld, yout_vld, peout_vld} !== {exp_xvld, exp_yvld, exp_pevld} ||
             (exp_xvld && xout_pkt !== exp_xpkt) ||
             ((exp_yvld || exp_pevld) && yout_pkt !== exp_ypkt)) begin
            failures++;
            $display("FAIL rand_outputs[%0d]: got xv=%b x=%h yv=%b pv=%b y=%h exp %b %h %b %b %h",
                     n, xout_vld, xout_pkt, yout_vld, peout_vld, yout_pkt,
                     exp_xvld, exp_xpkt, exp_yvld, exp_pevld, exp_ypkt);
         end
         checks++;
         if ({pein_rdy, inj_level, defl_cnt, inj_cnt, s_defl_cnt, s_inj_cnt} !==
             {exp_rdy, 3'(mq.size()), 16'(exp_defl), 16'(exp_inj), 2'(sat3(exp_defl)), 2'(sat3(exp_inj))}) begin
            failures++;
            $display("FAIL rand_state[%0d]: got rdy=%b lvl=%0d defl=%0d inj=%0d sd=%0d si=%0d exp %b %0d %0d %0d %0d %0d",
                     n, pein_rdy, inj_level, defl_cnt, inj_cnt, s_defl_cnt, s_inj_cnt,
                     exp_rdy, mq.size(), exp_defl, exp_inj, sat3(exp_defl), sat3(exp_inj));
         end
      end
      rst = 0; idle_inputs();
      tick();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_route_w();
      test_deflect();
      test_fifo_fill();
      test_full_push_pop();
      test_saturation_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
